// File: rtl/otp_pkg.sv
// otp_pkg: shared FSM type, BCD constants and digit increment helper for otp_keypad_entry
package otp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [1:0] DIGIT_MSB = 2'd3;
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return d >= BCD_MAX ? 4'd0 : d + 4'd1;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, debouncer (present only with OTP_DEBOUNCE_EN) and rising-edge detector
module btn_debounce #(
  parameter int DEB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic s1, s2, level, level_q, armed;
  logic [1:0] settle;
  if (DEB_CYCLES < 1) begin : g_bad
    $error("DEB_CYCLES must be at least 1");
  end
`ifdef OTP_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt;
  // level rises on the DEB_CYCLES-th consecutive high sample; any low sample restarts the count
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      level <= 1'b0;
    end else begin
      cnt <= !s2 ? '0 : cnt == CW'(DEB_CYCLES) ? cnt : cnt + 1'b1;
      level <= s2 && cnt >= CW'(DEB_CYCLES - 1);
    end
`else
  assign level = s2;
`endif
  // synchronizer and edge detect; a button held across reset stays disarmed until seen released
  always_ff @(posedge clk)
    if (rst) begin
      {s1, s2, level_q, press, armed} <= '0;
      settle <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      settle <= {settle[0], 1'b1};
      armed <= armed | (settle[1] & ~s2);
      level_q <= level;
      press <= armed & level & ~level_q;
    end
endmodule

// File: rtl/otp_keypad_entry.sv
// otp_keypad_entry: four-digit BCD OTP keypad entry FSM; button debouncing enabled by OTP_DEBOUNCE_EN
module otp_keypad_entry
  import otp_pkg::*;
#(
  parameter int DEB_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_next,
  input  logic        btn_enter,
  input  logic        btn_clr,
  input  logic        lock,
  output logic [15:0] user_otp,
  output logic [1:0]  digit_sel,
  output logic        entry_active,
  output logic        otp_valid
);
  logic [3:0] raw, ev;
  state_t state, state_n;
  logic [15:0] otp_n, base;
  logic [1:0] sel_n, bsel;
  logic valid_n;
  assign raw = {btn_clr, btn_enter, btn_next, btn_inc};
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk(clk),
      .rst(rst),
      .btn(raw[i]),
      .press(ev[i])
    );
  end
  // state and datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      user_otp <= '0;
      digit_sel <= DIGIT_MSB;
      otp_valid <= 1'b0;
    end else begin
      state <= state_n;
      user_otp <= otp_n;
      digit_sel <= sel_n;
      otp_valid <= valid_n;
    end
  assign entry_active = state == ENTRY;
  assign base = state == ENTRY ? user_otp : '0;
  assign bsel = state == ENTRY ? digit_sel : DIGIT_MSB;
  // next state: clr > enter > next > inc, everything discarded while locked; IDLE/DONE edits start blank on digit 3
  always_comb begin
    state_n = state;
    otp_n = user_otp;
    sel_n = digit_sel;
    valid_n = 1'b0;
    if (!lock) begin
      if (ev[3]) begin
        state_n = IDLE;
        otp_n = '0;
        sel_n = DIGIT_MSB;
      end else if (ev[2]) begin
        if (state == ENTRY) begin
          state_n = DONE;
          valid_n = 1'b1;
        end
      end else if (ev[1]) begin
        if (state != DONE) begin
          state_n = ENTRY;
          sel_n = bsel - 2'd1;
        end
      end else if (ev[0]) begin
        state_n = ENTRY;
        sel_n = bsel;
        otp_n = base;
        otp_n[{bsel, 2'b00} +: 4] = bcd_inc(base[{bsel, 2'b00} +: 4]);
      end
    end
  end
endmodule

// File: tb/tb_otp_keypad_entry.sv
// tb_otp_keypad_entry: randomized scoreboard bench against a rule-level model of the keypad entry
module tb_otp_keypad_entry;
  localparam int DEB = 8;
`ifdef OTP_DEBOUNCE_EN
  localparam int LAT = DEB + 4;
  localparam int MINP = DEB;
`else
  localparam int LAT = 4;
  localparam int MINP = 1;
`endif
  localparam logic [3:0] INC = 4'd1, NXT = 4'd2, ENT = 4'd4, CLR = 4'd8;
  typedef struct {
    int cyc;
    logic [15:0] otp;
    logic [1:0] sel;
    logic act;
    logic val;
  } exp_t;
  logic clk = 0, rst = 1, btn_inc = 0, btn_next = 0, btn_enter = 0, btn_clr = 0, lock = 0;
  logic [15:0] user_otp;
  logic [1:0] digit_sel;
  logic entry_active, otp_valid;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0;
  bit done = 0;
  int md[4];
  int msel = 3, mst = 0;
  logic [15:0] po;
  logic [1:0] ps;
  logic pa, pv;

  otp_keypad_entry #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_next(btn_next), .btn_enter(btn_enter),
    .btn_clr(btn_clr), .lock(lock), .user_otp(user_otp), .digit_sel(digit_sel),
    .entry_active(entry_active), .otp_valid(otp_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] motp();
    return 16'(md[3] * 4096 + md[2] * 256 + md[1] * 16 + md[0]);
  endfunction

  task automatic push(input int at, input logic val);
    exp_t x;
    x.cyc = at;
    x.otp = motp();
    x.sel = 2'(msel);
    x.act = mst == 1;
    x.val = val;
    q.push_back(x);
  endtask

  // model: mst 0=idle 1=entry 2=done; one press event applied with clr > enter > next > inc
  task automatic model_event(input logic [3:0] m, input logic lk, input int at);
    logic [15:0] o = motp();
    int s = msel, st = mst;
    if (lk) return;
    if (m[3]) begin
      mst = 0; msel = 3;
      foreach (md[i]) md[i] = 0;
    end else if (m[2]) begin
      if (mst == 1) begin
        mst = 2;
        push(at, 1);
        push(at + 1, 0);
      end
      return;
    end else if (m[1]) begin
      if (mst != 2) begin
        mst = 1;
        msel = (msel + 3) % 4;
      end
    end else begin
      if (mst != 1) begin
        foreach (md[i]) md[i] = 0;
        msel = 3;
      end
      mst = 1;
      md[msel] = (md[msel] + 1) % 10;
    end
    if (o != motp() || s != msel || (st == 1) != (mst == 1)) push(at, 0);
  endtask

  task automatic press(input logic [3:0] m, input int hold, input logic lk);
    @(negedge clk);
    lock = lk;
    {btn_clr, btn_enter, btn_next, btn_inc} = m;
    if (hold >= MINP) model_event(m, lk, cyc + LAT);
    repeat (hold) @(negedge clk);
    {btn_clr, btn_enter, btn_next, btn_inc} = '0;
    repeat (LAT + 4) @(negedge clk);
    lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    if (mst != 0) begin
      mst = 0; msel = 3;
      foreach (md[i]) md[i] = 0;
      push(cyc + 1, 0);
    end
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
  endtask

  // monitor: every output change must match the oldest expectation, on its exact cycle
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL missing change: wanted at cycle %0d otp=%h sel=%0d, outputs did not change", q[0].cyc, q[0].otp, q[0].sel);
      void'(q.pop_front());
    end
    if (user_otp !== po || digit_sel !== ps || entry_active !== pa || otp_valid !== pv) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected change: cycle %0d got otp=%h sel=%0d act=%b valid=%b", cyc, user_otp, digit_sel, entry_active, otp_valid);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.otp !== user_otp || e.sel !== digit_sel || e.act !== entry_active || e.val !== otp_valid) begin
          bad++;
          $display("FAIL change: got cycle %0d otp=%h sel=%0d act=%b valid=%b, wanted cycle %0d otp=%h sel=%0d act=%b valid=%b",
                   cyc, user_otp, digit_sel, entry_active, otp_valid, e.cyc, e.otp, e.sel, e.act, e.val);
        end
      end
    end
    po <= user_otp; ps <= digit_sel; pa <= entry_active; pv <= otp_valid;
    if (done) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL pending: %0d expected changes never observed", q.size());
      end
      total++;
      if (user_otp !== motp() || digit_sel !== 2'(msel)) begin
        bad++;
        $display("FAIL final: got otp=%h sel=%0d, wanted otp=%h sel=%0d", user_otp, digit_sel, motp(), msel);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r, hold;
    logic [3:0] m;
    foreach (md[i]) md[i] = 0;
    push(1, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    repeat (3) press(INC, MINP, 0);
    press(NXT, MINP, 0);
    repeat (5) press(INC, MINP, 0);
    repeat (2) press(NXT, MINP, 0);
    repeat (9) press(INC, MINP, 0);
    press(ENT, MINP, 0);
    press(ENT, MINP, 0);
    press(NXT, MINP, 0);
    press(INC, MINP, 0);
    press(CLR, MINP, 0);
    press(CLR, MINP, 0);
    repeat (10) press(INC, MINP, 0);
    repeat (4) press(NXT, MINP, 0);
`ifdef OTP_DEBOUNCE_EN
    press(INC, DEB - 1, 0);
    press(INC, 1, 0);
`endif
    press(INC, 50, 0);
    press(ENT | CLR, MINP, 0);
    press(INC, MINP, 0);
    press(INC, MINP, 1);
    press(ENT, MINP, 1);
    press(INC, MINP, 0);
    press(CLR, MINP, 0);
    repeat (4) press(INC, MINP, 0);
    press(NXT, MINP, 0);
    repeat (2) press(INC, MINP, 0);
    do_reset();
    @(negedge clk);
    btn_inc = 1;
    model_event(INC, 0, cyc + LAT);
    repeat (LAT + 3) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    btn_inc = 0;
    repeat (LAT + 4) @(negedge clk);
    press(INC, MINP, 0);
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) m = 4'($urandom_range(1, 15));
      else begin
        r = $urandom_range(0, 5);
        m = r < 3 ? INC : r == 3 ? NXT : r == 4 ? ENT : CLR;
      end
      hold = $urandom_range(MINP, MINP + 12);
      if (MINP > 1 && $urandom_range(0, 5) == 0) hold = $urandom_range(1, MINP - 1);
      press(m, hold, $urandom_range(0, 7) == 0);
    end
    done = 1;
  end
endmodule
